// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises BUS_WIDTH-bit words as back-to-back 8N1 frames,
// least-significant byte first, behind a valid/ready word interface.
module uart_word_tx #(
    parameter int unsigned CLK_FREQ     = 100000000,
    parameter int unsigned BIT_RATE     = 115200,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned BUS_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BIT_RATE;
    localparam int unsigned NUM_FRAMES   = BUS_WIDTH / PAYLOAD_BITS;
    localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W        = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
    localparam int unsigned FRAME_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(PAYLOAD_BITS - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);

    if (BUS_WIDTH % PAYLOAD_BITS != 0) begin : g_bad_width
        $error("uart_word_tx: BUS_WIDTH must be a multiple of PAYLOAD_BITS");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
        $error("uart_word_tx: CLK_FREQ/BIT_RATE must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [BUS_WIDTH-1:0] shift_q, shift_d;
    logic [BAUD_W-1:0]    baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic                 tx_q, tx_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [PAYLOAD_BITS-1:0] cur_byte;
    logic [BIT_W-1:0]        next_bit;
    logic                    baud_tick;

    assign cur_byte  = shift_q[PAYLOAD_BITS-1:0];
    assign next_bit  = bit_cnt_q + 1'b1;
    assign baud_tick = (baud_cnt_q == BAUD_LAST);

    // Next-state and registered-output logic; tx is computed one cycle ahead
    // so the line changes exactly on each bit boundary.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        tx_d        = tx_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d       = 1'b1;
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
                if (in_valid && in_ready_q) begin
                    shift_d     = in_data;
                    frame_cnt_d = '0;
                    baud_cnt_d  = '0;
                    tx_d        = 1'b0;
                    in_ready_d  = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = cur_byte[0];
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = next_bit;
                        tx_d      = cur_byte[next_bit];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    baud_cnt_d = '0;
                    if (frame_cnt_q != FRAME_LAST) begin
                        shift_d     = shift_q >> PAYLOAD_BITS;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        tx_d        = 1'b0;
                        state_d     = START;
                    end else begin
                        in_ready_d = 1'b1;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            tx_q        <= 1'b1;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            tx_q        <= tx_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign tx       = tx_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Testbench for uart_word_tx: line waveform model, handshake checks and a
// UART receiver scoreboard on the tx pin.
module tb_uart_word_tx;

    localparam int CPB       = 8;
    localparam int FRAME_CYC = 10 * CPB;
    localparam int WORD_CYC  = 4 * FRAME_CYC;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        tx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] rx_q[$];

    uart_word_tx #(
        .CLK_FREQ    (8000000),
        .BIT_RATE    (1000000),
        .PAYLOAD_BITS(8),
        .BUS_WIDTH   (32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level k cycles after the accept edge for an 8N1 word.
    function automatic logic exp_line(input logic [31:0] w, input int k);
        int f;
        int p;
        f = k / FRAME_CYC;
        p = (k % FRAME_CYC) / CPB;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return w[f*8 + p - 1];
    endfunction

    // Receiver model: detect start edge, sample each bit at its middle.
    bit          rx_active = 0;
    int          rx_cnt    = 0;
    int          rx_nbytes = 0;
    int          frame_err = 0;
    logic [7:0]  rx_byte;
    logic [31:0] rx_word;
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            rx_active = 0;
            rx_nbytes = 0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                if (rx_cnt / CPB == 0) begin
                    if (tx !== 1'b0) frame_err++;
                end else if (rx_cnt / CPB <= 8) begin
                    rx_byte[rx_cnt/CPB - 1] = tx;
                end else begin
                    if (tx !== 1'b1) frame_err++;
                    rx_word[rx_nbytes*8 +: 8] = rx_byte;
                    rx_nbytes++;
                    rx_active = 0;
                    if (rx_nbytes == 4) begin
                        rx_q.push_back(rx_word);
                        rx_nbytes = 0;
                    end
                end
            end
        end
    end

    // Sends one word from a negedge with in_ready high; returns at the negedge
    // after the done edge (plus one more cycle if not chaining).
    task automatic xmit(input logic [31:0] w, input bit chain, input logic [31:0] nxt,
                        input bit noise, output logic [9:0] f0);
        int wmis;
        int bad;
        wmis = 0;
        bad  = 0;
        in_data  = w;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(w);
        for (int k = 0; k < WORD_CYC; k++) begin
            @(negedge clk);
            if (tx !== exp_line(w, k)) wmis++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) bad++;
            if (k < FRAME_CYC && k % CPB == CPB / 2) f0[k/CPB] = tx;
            if (k == WORD_CYC - 1) begin
                in_valid = chain;
                in_data  = chain ? nxt : $urandom;
            end else if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = $urandom;
            end else if (k == 0) begin
                in_valid = chain;
                in_data  = chain ? nxt : ~w;
            end
        end
        check("wave", 64'(wmis), 64'd0);
        check("busy_hs", 64'(bad), 64'd0);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd1);
        check("ready_back", 64'(in_ready), 64'd1);
        check("busy_clear", 64'(busy), 64'd0);
        check("tx_idle_gap", 64'(tx), 64'd1);
        if (!chain) begin
            @(negedge clk);
            check("done_one_cycle", 64'(done), 64'd0);
            check("idle_tx", 64'(tx), 64'd1);
        end
    endtask

    initial begin
        logic [9:0]  f0;
        logic [31:0] words[100];
        int          bad;
        bit          ch;
        bit          nz;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset held 3 cycles, then idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        bad = 0;
        if (tx !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check("reset_idle", 64'(bad), 64'd0);

        // Single word, frame 0 bit pattern.
        xmit(32'h0000004A, 1'b0, '0, 1'b0, f0);
        check("frame0_bits", 64'(f0), 64'(10'b1010010100));

        // Two back-to-back words with in_valid held.
        xmit(32'hDEADBEEF, 1'b1, 32'h12345678, 1'b0, f0);
        xmit(32'h12345678, 1'b0, '0, 1'b0, f0);

        // Noise on in_data/in_valid while busy.
        xmit(32'hCAFEF00D, 1'b0, '0, 1'b1, f0);

        // Reset during data bit 3 of frame 2.
        in_data  = 32'h87654321;
        in_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 2 * FRAME_CYC + 4 * CPB + 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort_tx", 64'(tx), 64'd1);
        check("abort_ready", 64'(in_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || tx !== 1'b1 || in_ready !== 1'b1) bad++;
        end
        check("abort_no_done", 64'(bad), 64'd0);
        xmit(32'hA5A5A5A5, 1'b0, '0, 1'b0, f0);

        // Random words, randomly chained and with random noise while busy.
        for (int i = 0; i < 100; i++) words[i] = $urandom;
        for (int i = 0; i < 100; i++) begin
            ch = (i < 99) ? 1'($urandom_range(0, 1)) : 1'b0;
            nz = 1'($urandom_range(0, 1));
            xmit(words[i], ch, (i < 99) ? words[i+1] : 32'h0, nz, f0);
        end

        repeat (20) @(negedge clk);
        check("framing", 64'(frame_err), 64'd0);
        check("rx_count", 64'(rx_q.size()), 64'(exp_q.size()));
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            check("rx_word", 64'(rx_q.pop_front()), 64'(exp_q.pop_front()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
